// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester-side and FIFO-side signals around the write arbiter.
// The master modport is the arbiter; slave is the requesters plus the FIFO.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [2:0]            grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_wdata, fifo_winc, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_wdata, fifo_winc, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// One IDLE cycle per arbitration; a grant lasts until req_last or MAXBURST beats.
module fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input logic          wclk,
  input logic          wrst_n,
  fifo_wr_arb_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state_q, state_d;
  logic [2:0] grantId_q, grantId_d;
  logic [2:0] rrLast_q, rrLast_d;
  logic [3:0] beatCnt_q, beatCnt_d;

  logic [NREQ-1:0]   grantOh;
  logic              ownValid;
  logic              ownLast;
  logic              accept;
  logic              anyValid;
  logic [3:0]        shAmt;
  logic [2*NREQ-1:0] rotFull;
  logic [NREQ-1:0]   rotLow;
  int                first;
  int                pickSum;
  logic [2:0]        pickIdx;

  logic [NREQ-1:0]  reqReady;
  logic [DSIZE-1:0] wdata;
  logic             winc;

  assign grantOh  = {{(NREQ-1){1'b0}}, 1'b1} << grantId_q;
  assign ownValid = |(bus.req_valid & grantOh);
  assign ownLast  = |(bus.req_last & grantOh);
  assign anyValid = |bus.req_valid;
  assign accept   = (state_q == BURST) && ownValid && !bus.fifo_wfull;

  // Rotate the valid vector so bit 0 is rr_last+1, take the lowest set bit,
  // then undo the rotation with a wrap modulo NREQ.
  always_comb begin
    shAmt   = {1'b0, rrLast_q} + 4'd1;
    rotFull = {bus.req_valid, bus.req_valid} >> shAmt;
    rotLow  = rotFull[NREQ-1:0];
    first   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rotLow[j]) first = j;
    end
    pickSum = int'(rrLast_q) + 1 + first;
    if (pickSum >= NREQ) pickSum = pickSum - NREQ;
    pickIdx = 3'(pickSum);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= IDLE;
      grantId_q <= 3'd0;
      rrLast_q  <= 3'(NREQ - 1);
      beatCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      rrLast_q  <= rrLast_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // A full FIFO blocks acceptance entirely, so a last beat that meets
  // wfull leaves the burst untouched until the beat actually goes in.
  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    rrLast_d  = rrLast_q;
    beatCnt_d = beatCnt_q;
    reqReady  = '0;
    wdata     = '0;
    winc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          grantId_d = pickIdx;
          beatCnt_d = 4'd0;
          state_d   = BURST;
        end
      end
      BURST: begin
        reqReady = bus.fifo_wfull ? '0 : grantOh;
        winc     = ownValid && !bus.fifo_wfull;
        for (int i = 0; i < NREQ; i++) begin
          if (grantId_q == 3'(i)) wdata = bus.req_data[i*DSIZE +: DSIZE];
        end
        if (accept) begin
          beatCnt_d = beatCnt_q + 4'd1;
          if (ownLast || (beatCnt_q + 4'd1 == 4'(MAXBURST))) begin
            rrLast_d = grantId_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = reqReady;
  assign bus.fifo_wdata = wdata;
  assign bus.fifo_winc  = winc;
  assign bus.grant_id   = grantId_q;
  assign bus.busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: a per-cycle vector table plus hand-written
// sequences for asynchronous reset in the middle of a burst.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;

  logic wclk;
  logic wrst_n;

  fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(4)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  expReady;
    logic        expWinc;
    logic [7:0]  expWdata;
    logic        expBusy;
    logic [2:0]  expGrant;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic addVec(input logic [3:0] valid, input logic [3:0] last, input logic full,
                        input logic [31:0] data, input logic [3:0] expReady,
                        input logic expWinc, input logic [7:0] expWdata,
                        input logic expBusy, input logic [2:0] expGrant);
    vec_t v;
    v.valid = valid; v.last = last; v.full = full; v.data = data;
    v.expReady = expReady; v.expWinc = expWinc; v.expWdata = expWdata;
    v.expBusy = expBusy; v.expGrant = expGrant;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                               input logic full, input logic [31:0] data);
    bus.req_valid  = valid;
    bus.req_last   = last;
    bus.fifo_wfull = full;
    bus.req_data   = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " busy"},  32'(bus.busy), 32'd0);
    checkOutput({tag, " winc"},  32'(bus.fifo_winc), 32'd0);
    checkOutput({tag, " ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, " wdata"}, 32'(bus.fifo_wdata), 32'd0);
  endtask

  initial begin
    // requester 1: three beats A1,A2,A3 with last on the third
    addVec(4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0010, 1, 8'hA1, 1, 3'd1);
    addVec(4'b0010, 4'b0000, 0, 32'h0000_A200, 4'b0010, 1, 8'hA2, 1, 3'd1);
    addVec(4'b0010, 4'b0010, 0, 32'h0000_A300, 4'b0010, 1, 8'hA3, 1, 3'd1);
    addVec(4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0, 3'd0);
    // all valid, single-beat packets; rr_last=1 so order is 2,3,0,1
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0100, 1, 8'hC2, 1, 3'd2);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b1000, 1, 8'hD3, 1, 3'd3);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0001, 1, 8'hA0, 1, 3'd0);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b1111, 4'b1111, 0, 32'hD3C2_B1A0, 4'b0010, 1, 8'hB1, 1, 3'd1);
    // full gating, including last beat coinciding with full
    addVec(4'b0001, 4'b0000, 0, 32'h0000_00E0, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b0001, 4'b0000, 1, 32'h0000_00E0, 4'b0000, 0, 8'hE0, 1, 3'd0);
    addVec(4'b0001, 4'b0001, 1, 32'h0000_00E0, 4'b0000, 0, 8'hE0, 1, 3'd0);
    addVec(4'b0001, 4'b0001, 0, 32'h0000_00E0, 4'b0001, 1, 8'hE0, 1, 3'd0);
    addVec(4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 8'h00, 0, 3'd0);
    // owner 2 drops valid while 1 waits, then hits MAXBURST
    addVec(4'b0100, 4'b0000, 0, 32'h00F0_0000, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b0100, 4'b0000, 0, 32'h00F0_0000, 4'b0100, 1, 8'hF0, 1, 3'd2);
    addVec(4'b0010, 4'b0000, 0, 32'h00F1_1100, 4'b0100, 0, 8'hF1, 1, 3'd2);
    addVec(4'b0010, 4'b0000, 0, 32'h00F1_1100, 4'b0100, 0, 8'hF1, 1, 3'd2);
    addVec(4'b0010, 4'b0000, 0, 32'h00F1_1100, 4'b0100, 0, 8'hF1, 1, 3'd2);
    addVec(4'b0110, 4'b0000, 0, 32'h00F1_1100, 4'b0100, 1, 8'hF1, 1, 3'd2);
    addVec(4'b0110, 4'b0000, 0, 32'h00F2_1100, 4'b0100, 1, 8'hF2, 1, 3'd2);
    addVec(4'b0110, 4'b0000, 0, 32'h00F3_1100, 4'b0100, 1, 8'hF3, 1, 3'd2);
    addVec(4'b0110, 4'b0000, 0, 32'h00F3_1100, 4'b0000, 0, 8'h00, 0, 3'd0);
    addVec(4'b0110, 4'b0000, 0, 32'h00F3_1100, 4'b0010, 1, 8'h11, 1, 3'd1);
    addVec(4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0010, 0, 8'h00, 1, 3'd1);

    wrst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    @(negedge wclk);
    @(negedge wclk);
    checkIdleZero("reset");
    checkOutput("reset grant", 32'(bus.grant_id), 32'd0);
    wrst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge wclk);
      applyStimulus(vecs[k].valid, vecs[k].last, vecs[k].full, vecs[k].data);
      #1;
      checkOutput($sformatf("v%0d ready", k), 32'(bus.req_ready), 32'(vecs[k].expReady));
      checkOutput($sformatf("v%0d winc", k),  32'(bus.fifo_winc), 32'(vecs[k].expWinc));
      checkOutput($sformatf("v%0d wdata", k), 32'(bus.fifo_wdata), 32'(vecs[k].expWdata));
      checkOutput($sformatf("v%0d busy", k),  32'(bus.busy), 32'(vecs[k].expBusy));
      if (vecs[k].expBusy)
        checkOutput($sformatf("v%0d grant", k), 32'(bus.grant_id), 32'(vecs[k].expGrant));
    end

    // clean reset, then requester 3 starts a burst and is reset during beat 2
    @(negedge wclk);
    wrst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    #1;
    checkIdleZero("rst1");
    @(negedge wclk);
    wrst_n = 1'b1;
    applyStimulus(4'b1000, 4'b0000, 1'b0, 32'h3100_0000);
    #1;
    checkOutput("r3 idle busy", 32'(bus.busy), 32'd0);
    @(negedge wclk);
    #1;
    checkOutput("r3 grant", 32'(bus.grant_id), 32'd3);
    checkOutput("r3 beat1 wdata", 32'(bus.fifo_wdata), 32'h31);
    @(negedge wclk);
    applyStimulus(4'b1000, 4'b0000, 1'b0, 32'h3200_0000);
    #1;
    checkOutput("r3 beat2 winc", 32'(bus.fifo_winc), 32'd1);
    checkOutput("r3 beat2 wdata", 32'(bus.fifo_wdata), 32'h32);
    wrst_n = 1'b0;
    #1;
    checkIdleZero("midrst");
    checkOutput("midrst grant", 32'(bus.grant_id), 32'd0);
    applyStimulus(4'b1001, 4'b0000, 1'b0, 32'h3200_00C0);
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    checkOutput("post rst idle busy", 32'(bus.busy), 32'd0);
    @(negedge wclk);
    #1;
    checkOutput("post rst busy", 32'(bus.busy), 32'd1);
    checkOutput("post rst grant", 32'(bus.grant_id), 32'd0);
    checkOutput("post rst ready", 32'(bus.req_ready), 32'b0001);
    checkOutput("post rst wdata", 32'(bus.fifo_wdata), 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
